// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default widths for the data-RAM arbiter between the core and the aux port.
package dmem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 24;

    typedef enum logic {ARB, AUX_BURST} arb_state_t;
    typedef enum logic {OWN_CPU, OWN_AUX} owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundles the core, aux and RAM-side signals of the data-RAM arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = dmem_arb_pkg::ADDR_W,
    parameter int DATA_W = dmem_arb_pkg::DATA_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              aux_req;
    logic              aux_we;
    logic              aux_lock;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata;
    logic              aux_gnt;
    logic              aux_rvalid;
    logic [DATA_W-1:0] aux_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  aux_req, aux_we, aux_lock, aux_addr, aux_wdata,
        output aux_gnt, aux_rvalid, aux_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    // Requester / RAM side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output aux_req, aux_we, aux_lock, aux_addr, aux_wdata,
        input  aux_gnt, aux_rvalid, aux_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter; clr has priority, and clr together with inc loads 1.
module sat_counter #(
    parameter  int MAX = 4,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         at_max
);

    logic [W-1:0] value_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else if (clr) begin
            value_q <= inc ? W'(1) : '0;
        end else if (inc && !at_max) begin
            value_q <= value_q + W'(1);
        end
    end

    assign value  = value_q;
    assign at_max = (value_q == W'(MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Core-priority arbiter for the single-port data RAM with aux starvation guard and bounded aux bursts.
module dmem_arbiter #(
    parameter int ADDR_W    = dmem_arb_pkg::ADDR_W,
    parameter int DATA_W    = dmem_arb_pkg::DATA_W,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 16
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    import dmem_arb_pkg::*;

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    arb_state_t         state_q, state_d;
    owner_t             owner_q;
    logic               rvalid_q;
    logic               cpu_gnt, aux_gnt, in_burst;
    logic               wait_inc, wait_clr, wait_at_max;
    logic               burst_inc, burst_clr, burst_at_max;
    logic [WAIT_W-1:0]  wait_val;
    logic [BURST_W-1:0] burst_val;

    always_comb begin
        cpu_gnt  = 1'b0;
        aux_gnt  = 1'b0;
        in_burst = 1'b0;
        state_d  = ARB;
        if (!reset) begin
            if (state_q == AUX_BURST && bus.aux_req && bus.aux_lock && !burst_at_max) begin
                aux_gnt  = 1'b1;
                in_burst = 1'b1;
            end else if (state_q == AUX_BURST && burst_at_max && bus.cpu_req) begin
                // Forced release after a full-length burst: core gets this cycle.
                cpu_gnt = 1'b1;
            end else if (wait_at_max && bus.aux_req) begin
                aux_gnt = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (bus.aux_req) begin
                aux_gnt = 1'b1;
            end
            if (aux_gnt && bus.aux_lock) begin
                state_d = AUX_BURST;
            end
        end
    end

    assign wait_inc  = bus.aux_req && !aux_gnt;
    assign wait_clr  = !bus.aux_req || aux_gnt;
    assign burst_inc = aux_gnt && (state_d == AUX_BURST);
    assign burst_clr = !in_burst;

    sat_counter #(.MAX(MAX_WAIT)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wait_inc),
        .clr   (wait_clr),
        .value (wait_val),
        .at_max(wait_at_max)
    );

    sat_counter #(.MAX(MAX_BURST)) u_burst_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (burst_inc),
        .clr   (burst_clr),
        .value (burst_val),
        .at_max(burst_at_max)
    );

    // Only the saturation flags steer arbitration; raw counts are kept for visibility.
    logic unused_cnt;
    assign unused_cnt = ^{wait_val, burst_val};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB;
            rvalid_q <= 1'b0;
            owner_q  <= OWN_CPU;
        end else begin
            state_q  <= state_d;
            rvalid_q <= (cpu_gnt && !bus.cpu_we) || (aux_gnt && !bus.aux_we);
            owner_q  <= aux_gnt ? OWN_AUX : OWN_CPU;
        end
    end

    assign bus.cpu_stall  = bus.cpu_req && !cpu_gnt;
    assign bus.aux_gnt    = aux_gnt;

    assign bus.mem_we     = (cpu_gnt && bus.cpu_we) || (aux_gnt && bus.aux_we);
    assign bus.mem_addr   = aux_gnt ? bus.aux_addr  : cpu_gnt ? bus.cpu_addr  : {ADDR_W{1'b0}};
    assign bus.mem_wdata  = aux_gnt ? bus.aux_wdata : cpu_gnt ? bus.cpu_wdata : {DATA_W{1'b0}};

    // Gated by reset so a read accepted just before reset never returns.
    assign bus.cpu_rvalid = rvalid_q && (owner_q == OWN_CPU) && !reset;
    assign bus.aux_rvalid = rvalid_q && (owner_q == OWN_AUX) && !reset;
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.aux_rdata  = bus.aux_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};

endmodule
